switch_debouncer: RTL and testbench

//   Conditions the raw DE10-Lite slide switches before they reach the 2:1 mux
//   top level (i0, i1, sel) and any later LED/display logic.
//   - Each switch bit passes through a 2-flop synchronizer, then a per-bit

---
 rtl/switch_debouncer.sv | 97 +++++++++
 tb/tb_switch_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Per-bit slide-switch conditioner: 2-flop synchronizer, stability counter,
// registered debounced level plus one-cycle rise/fall pulses and a busy flag.
module switch_debouncer #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] busy
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A channel is counting whenever its synchronized level disagrees with
    // the accepted level; there is no other per-channel state to remember.
    typedef enum logic {
        CH_IDLE,
        CH_COUNT
    } ch_state_e;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] db_q,   db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    ch_state_e        ch_state [WIDTH];

    // NOTE: every output of this block is assigned a default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        busy_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]    = '0;
            ch_state[i] = (s2_q[i] != db_q[i]) ? CH_COUNT : CH_IDLE;

            if (ch_state[i] == CH_COUNT) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]   = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end

            // s1 becomes next cycle's s2, so this flags the channel as
            // counting for every cycle it spends in CH_COUNT.
            busy_d[i] = (s1_q[i] != db_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (s1 -> s2 shift relies on it).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            busy_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is cleared with the rest; this is what discards a pending change.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= sw_raw;
            s2_q   <= s1_q;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db   = db_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (WIDTH=3, STABLE_CYCLES=4): directed scenarios
// then random switch activity, checked against a sliding-window reference.
module tb_switch_debouncer;

    localparam int W = 3;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic [W-1:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: synchronizer stages, accepted level, last outputs and
    // the synchronized samples seen since the last reset (newest at the back).
    logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_busy;
    logic [W-1:0] hist [$];
    int           rise_tot [W];
    int           fall_tot [W];

    switch_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // A bit is accepted when its last S synchronized samples all disagree
    // with the current debounced level.
    task automatic model_edge(input logic [W-1:0] raw, input logic r);
        logic [W-1:0] db_new;
        logic         acc;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            m_rise = '0; m_fall = '0; m_busy = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > S) void'(hist.pop_front());
            db_new = m_db;
            for (int i = 0; i < W; i++) begin
                acc = (hist.size() == S);
                foreach (hist[j]) if (hist[j][i] == m_db[i]) acc = 1'b0;
                if (acc) db_new[i] = ~m_db[i];
            end
            m_rise = db_new & ~m_db;
            m_fall = ~db_new & m_db;
            m_db   = db_new;
            m_s2   = m_s1;
            m_s1   = raw;
            m_busy = m_s2 ^ m_db;
        end
    endtask

    task automatic step(input logic [W-1:0] raw, input logic r);
        sw_raw = raw;
        rst    = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        check("sw_db",   sw_db,   m_db);
        check("sw_rise", sw_rise, m_rise);
        check("sw_fall", sw_fall, m_fall);
        check("busy",    busy,    m_busy);
        check("rise_and_fall", sw_rise & sw_fall, '0);
        for (int i = 0; i < W; i++) begin
            rise_tot[i] += int'(sw_rise[i]);
            fall_tot[i] += int'(sw_fall[i]);
        end
    endtask

    task automatic clear_totals();
        for (int i = 0; i < W; i++) begin
            rise_tot[i] = 0;
            fall_tot[i] = 0;
        end
    endtask

    initial begin
        logic [W-1:0] r_raw;
        int           hold;

        sw_raw = '0;
        rst    = 1'b1;
        clear_totals();
        #2;

        // 1. Reset with all switches high, then release.
        for (int k = 0; k < 3; k++) begin
            step(3'b111, 1'b1);
            check("reset_db", sw_db, 3'b000);
        end
        for (int k = 1; k <= 8; k++) begin
            step(3'b111, 1'b0);
            if (k == 5) check("rel_db_k5", sw_db, 3'b000);
            if (k == 6) begin
                check("rel_db_k6",   sw_db,   3'b111);
                check("rel_rise_k6", sw_rise, 3'b111);
            end
            if (k == 7) check("rel_rise_k7", sw_rise, 3'b000);
        end

        // 2. Clean step on bit 0 after settling everything low.
        for (int k = 0; k < 8; k++) step(3'b000, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(3'b001, 1'b0);
            if (k == 1) check("step_busy_k1", busy, 3'b000);
            if (k == 2) check("step_busy_k2", busy, 3'b001);
            if (k == 5) begin
                check("step_db_k5",   sw_db, 3'b000);
                check("step_busy_k5", busy,  3'b001);
            end
            if (k == 6) begin
                check("step_db_k6",   sw_db,   3'b001);
                check("step_rise_k6", sw_rise, 3'b001);
                check("step_busy_k6", busy,    3'b000);
            end
        end

        // 3. Bounce on bit 1, then hold high.
        clear_totals();
        step(3'b011, 1'b0);
        step(3'b001, 1'b0);
        step(3'b011, 1'b0);
        step(3'b001, 1'b0);
        for (int k = 0; k < 10; k++) step(3'b011, 1'b0);
        check("bounce_rise_count", 3'(rise_tot[1]), 3'd1);
        check("bounce_fall_count", 3'(fall_tot[1]), 3'd0);
        check("bounce_db", sw_db, 3'b011);

        // 4. Short glitch on bit 2.
        clear_totals();
        for (int k = 0; k < 3; k++) step(3'b111, 1'b0);
        for (int k = 0; k < 8; k++) step(3'b011, 1'b0);
        check("glitch_pulses", 3'(rise_tot[2] + fall_tot[2]), 3'd0);
        check("glitch_db",   sw_db, 3'b011);
        check("glitch_busy", busy,  3'b000);

        // 5. Reset while bit 0 is mid-count toward 0.
        clear_totals();
        for (int k = 0; k < 4; k++) step(3'b010, 1'b0);
        step(3'b010, 1'b1);
        check("midrst_db",   sw_db,   3'b000);
        check("midrst_fall", sw_fall, 3'b000);
        check("midrst_busy", busy,    3'b000);
        check("midrst_fall_count", 3'(fall_tot[0]), 3'd0);
        for (int k = 0; k < 8; k++) step(3'b010, 1'b0);

        // 6. Simultaneous change on bits 0 and 2.
        for (int k = 0; k < 8; k++) step(3'b000, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(3'b101, 1'b0);
            if (k == 6) begin
                check("simul_db",   sw_db,   3'b101);
                check("simul_rise", sw_rise, 3'b101);
                check("simul_fall", sw_fall, 3'b000);
            end
        end

        // Random switch activity with random hold lengths and rare resets.
        for (int n = 0; n < 150; n++) begin
            r_raw = 3'($urandom);
            hold  = int'($urandom_range(1, 7));
            for (int k = 0; k < hold; k++) begin
                step(r_raw, ($urandom_range(0, 59) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
